// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared types and helpers for the AES stream controller
package aes_stream_pkg;
  localparam int AES_BLK_W = 128;
  typedef enum logic [2:0] {IDLE, KEY_REQ, KEY_WAIT, RUN, DRAIN} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/aes_stream_ctrl_if.sv
// aes_stream_ctrl_if: block input stream and per-direction result streams
interface aes_stream_ctrl_if;
  import aes_stream_pkg::*;
  logic in_valid, in_ready, in_dec;
  logic [AES_BLK_W-1:0] in_data;
  logic oenc_valid, oenc_ready, odec_valid, odec_ready;
  logic [AES_BLK_W-1:0] oenc_data, odec_data;
  modport master (
    output in_valid, in_dec, in_data, oenc_ready, odec_ready,
    input  in_ready, oenc_valid, oenc_data, odec_valid, odec_data
  );
  modport slave (
    input  in_valid, in_dec, in_data, oenc_ready, odec_ready,
    output in_ready, oenc_valid, oenc_data, odec_valid, odec_data
  );
endinterface

// File: rtl/aes_result_fifo.sv
// aes_result_fifo: single-clock first-word-fall-through result FIFO
module aes_result_fifo import aes_stream_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AES_BLK_W-1:0] din,
  output logic [AES_BLK_W-1:0] dout,
  output logic [CW-1:0]        count
);
  logic [AES_BLK_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop;
  assign do_pop = pop && count != '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
  // the issuer's credit accounting guarantees a free slot for every push
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !do_pop && count == CW'(DEPTH)));
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: credit-based block issue and result collection for the AES pipeline core
module aes_stream_ctrl import aes_stream_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_load,
  input  logic [AES_BLK_W-1:0] key_in,
  output logic                 key_valid,
  aes_stream_ctrl_if.slave     s,
  output logic                 err_timeout,
  output logic                 err_spurious,
  output logic                 core_reset_key,
  output logic [AES_BLK_W-1:0] core_key,
  input  logic                 core_ready_key,
  output logic                 core_reset_enc,
  output logic                 core_reset_dec,
  output logic [AES_BLK_W-1:0] core_block_enc,
  output logic [AES_BLK_W-1:0] core_block_dec,
  input  logic                 core_iready_enc,
  input  logic                 core_iready_dec,
  input  logic                 core_oready_enc,
  input  logic                 core_oready_dec,
  input  logic [AES_BLK_W-1:0] core_result_enc,
  input  logic [AES_BLK_W-1:0] core_result_dec
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int TW = cnt_w(KEY_TIMEOUT);
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);
  state_t state, state_n;
  logic [TW-1:0] tmo;
  logic [CW-1:0] inflight_enc, inflight_dec, count_enc, count_dec;
  logic credit_enc, credit_dec, issue_enc, issue_dec, done_enc, done_dec, tmo_hit, drained;
  // a block may only enter the core if its result already has a reserved FIFO slot
  assign credit_enc = {1'b0, count_enc} + {1'b0, inflight_enc} < CREDITS;
  assign credit_dec = {1'b0, count_dec} + {1'b0, inflight_dec} < CREDITS;
  assign issue_enc = s.in_valid && s.in_ready && !s.in_dec;
  assign issue_dec = s.in_valid && s.in_ready && s.in_dec;
  assign done_enc = core_oready_enc && inflight_enc != '0;
  assign done_dec = core_oready_dec && inflight_dec != '0;
  assign tmo_hit = tmo == TW'(KEY_TIMEOUT - 1);
  assign drained = inflight_enc == '0 && inflight_dec == '0;
  assign core_reset_enc = issue_enc;
  assign core_reset_dec = issue_dec;
  assign core_block_enc = s.in_data;
  assign core_block_dec = s.in_data;
  always_comb begin
    state_n = state;
    key_valid = state == RUN;
    core_reset_key = state == KEY_REQ;
    s.in_ready = state == RUN && (s.in_dec ? core_iready_dec && credit_dec : core_iready_enc && credit_enc);
    case (state)
      IDLE:     state_n = key_load ? KEY_REQ : IDLE;
      KEY_REQ:  state_n = KEY_WAIT;
      KEY_WAIT: state_n = core_ready_key ? RUN : tmo_hit ? IDLE : KEY_WAIT;
      RUN:      state_n = key_load ? DRAIN : RUN;
      DRAIN:    state_n = drained ? KEY_REQ : DRAIN;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      core_key <= '0;
      tmo <= '0;
      inflight_enc <= '0;
      inflight_dec <= '0;
      err_timeout <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_n;
      core_key <= key_load && (state == IDLE || state == RUN) ? key_in : core_key;
      tmo <= state == KEY_WAIT ? tmo + TW'(1) : '0;
      inflight_enc <= inflight_enc + CW'(issue_enc) - CW'(done_enc);
      inflight_dec <= inflight_dec + CW'(issue_dec) - CW'(done_dec);
      err_timeout <= err_timeout || (state == KEY_WAIT && !core_ready_key && tmo_hit);
      err_spurious <= err_spurious || (core_oready_enc && inflight_enc == '0) || (core_oready_dec && inflight_dec == '0);
    end
  end
  aes_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_enc (
    .clk(clk), .rst(reset), .push(done_enc), .pop(s.oenc_ready),
    .din(core_result_enc), .dout(s.oenc_data), .count(count_enc)
  );
  aes_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_dec (
    .clk(clk), .rst(reset), .push(done_dec), .pop(s.odec_ready),
    .din(core_result_dec), .dout(s.odec_data), .count(count_dec)
  );
  assign s.oenc_valid = count_enc != '0;
  assign s.odec_valid = count_dec != '0;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: directed bench for the AES stream controller with a fixed-latency core model
module tb_aes_stream_ctrl;
  localparam int LE = 10, LD = 12;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic clk = 1'b0, reset = 1'b1, key_load = 1'b0, core_ready_key = 1'b0, iready = 1'b1, man_od = 1'b0;
  logic [127:0] key_in = '0;
  logic key_valid, err_timeout, err_spurious, core_reset_key, core_reset_enc, core_reset_dec;
  logic core_oready_enc, core_oready_dec;
  logic [127:0] core_key, core_block_enc, core_block_dec, core_result_enc, core_result_dec;
  logic [LE-1:0] ev = '0;
  logic [LD-1:0] dv = '0;
  logic [127:0] ed [LE];
  logic [127:0] dd [LD];
  logic [128:0] tx_q [$];
  logic [127:0] exp_enc [$], exp_dec [$];
  int n_chk = 0, n_pass = 0, n_issued = 0, n_enc_out = 0, n_dec_out = 0, n_both = 0, n_key_pulse = 0;
  int base, base_e, base_d, wait_k;
  aes_stream_ctrl_if s();
  aes_stream_ctrl #(.FIFO_DEPTH(4), .KEY_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in), .key_valid(key_valid), .s(s),
    .err_timeout(err_timeout), .err_spurious(err_spurious),
    .core_reset_key(core_reset_key), .core_key(core_key), .core_ready_key(core_ready_key),
    .core_reset_enc(core_reset_enc), .core_reset_dec(core_reset_dec),
    .core_block_enc(core_block_enc), .core_block_dec(core_block_dec),
    .core_iready_enc(iready), .core_iready_dec(iready),
    .core_oready_enc(core_oready_enc), .core_oready_dec(core_oready_dec),
    .core_result_enc(core_result_enc), .core_result_dec(core_result_dec)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] core_f(input logic dec, input logic [127:0] b);
    return dec ? {b[63:0], b[127:64]} ^ {4{32'h5a5a5a5a}} : b ^ {4{32'ha5a5a5a5}};
  endfunction
  // fixed-latency stand-in for the AES core; it is never reset, like the real one
  always @(posedge clk) begin
    ev <= {ev[LE-2:0], core_reset_enc};
    dv <= {dv[LD-2:0], core_reset_dec};
    ed[0] <= core_f(1'b0, core_block_enc);
    dd[0] <= core_f(1'b1, core_block_dec);
    for (int i = 1; i < LE; i++) ed[i] <= ed[i-1];
    for (int i = 1; i < LD; i++) dd[i] <= dd[i-1];
    if (core_oready_enc && core_oready_dec) n_both <= n_both + 1;
    if (core_reset_key) n_key_pulse <= n_key_pulse + 1;
  end
  assign core_oready_enc = ev[LE-1];
  assign core_oready_dec = dv[LD-1] | man_od;
  assign core_result_enc = ed[LE-1];
  assign core_result_dec = dd[LD-1];
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic push_blk(input logic dec, input logic [127:0] d);
    tx_q.push_back({dec, d});
    if (dec) exp_dec.push_back(core_f(1'b1, d));
    else exp_enc.push_back(core_f(1'b0, d));
  endtask
  task automatic step();
    s.in_valid = tx_q.size() != 0;
    if (tx_q.size() != 0) {s.in_dec, s.in_data} = tx_q[0];
    @(negedge clk);
    if (s.in_valid && s.in_ready) begin
      void'(tx_q.pop_front());
      n_issued++;
    end
    if (s.oenc_valid && s.oenc_ready) begin
      n_enc_out++;
      if (exp_enc.size() == 0) chk("enc_extra", s.oenc_valid, 1'b0);
      else chk("enc_data", s.oenc_data, exp_enc.pop_front());
    end
    if (s.odec_valid && s.odec_ready) begin
      n_dec_out++;
      if (exp_dec.size() == 0) chk("dec_extra", s.odec_valid, 1'b0);
      else chk("dec_data", s.odec_data, exp_dec.pop_front());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    s.in_valid = 1'b0;
    s.in_dec = 1'b0;
    s.in_data = '0;
    s.oenc_ready = 1'b0;
    s.odec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_valid", key_valid, 0);
    chk("rst_in_ready", s.in_ready, 0);
    chk("rst_key_pulse", core_reset_key, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_oenc_valid", s.oenc_valid, 0);
    chk("rst_odec_valid", s.odec_valid, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_spurious", err_spurious, 0);
    reset = 1'b0;
    key_load = 1'b1;
    key_in = K1;
    chk("idle_no_key_pulse", core_reset_key, 0);
    step();
    key_load = 1'b0;
    key_in = '0;
    chk("key_req_pulse", core_reset_key, 1);
    chk("key_req_core_key", core_key, K1);
    step();
    chk("key_wait_pulse_low", core_reset_key, 0);
    repeat (3) step();
    core_ready_key = 1'b1;
    chk("key_valid_before_ready", key_valid, 0);
    step();
    core_ready_key = 1'b0;
    chk("key_valid_after_ready", key_valid, 1);
    chk("key_pulse_count", n_key_pulse, 1);
    chk("core_key_held", core_key, K1);
    for (int i = 0; i < 6; i++) push_blk(1'b0, {4{32'(32'h10000000 + i)}});
    base = n_issued;
    repeat (30) step();
    chk("bp_issued", n_issued - base, 4);
    chk("bp_in_ready", s.in_ready, 0);
    chk("bp_oenc_valid", s.oenc_valid, 1);
    s.oenc_ready = 1'b1;
    for (int k = 0; k < 80 && n_enc_out < 6; k++) step();
    chk("bp_out_count", n_enc_out, 6);
    chk("bp_issued_all", n_issued - base, 6);
    s.odec_ready = 1'b1;
    base_e = n_enc_out;
    base_d = n_dec_out;
    for (int i = 0; i < 8; i++) push_blk(!i[1], {4{32'(32'h20000000 + i)}});
    for (int k = 0; k < 80 && (n_enc_out - base_e < 4 || n_dec_out - base_d < 4); k++) step();
    chk("mixed_enc_count", n_enc_out - base_e, 4);
    chk("mixed_dec_count", n_dec_out - base_d, 4);
    chk("mixed_same_cycle_oready", n_both > 0, 1);
    s.oenc_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_blk(1'b0, {4{32'(32'h30000000 + i)}});
    base = n_issued;
    repeat (3) step();
    key_load = 1'b1;
    key_in = K2;
    step();
    key_load = 1'b0;
    chk("drain_key_valid", key_valid, 0);
    push_blk(1'b0, {4{32'h30000003}});
    wait_k = 0;
    while (!core_reset_key && wait_k < 40) begin
      step();
      wait_k++;
    end
    chk("rekey_wait", wait_k, 10);
    chk("rekey_issued", n_issued - base, 3);
    chk("rekey_core_key", core_key, K2);
    chk("rekey_fifo_kept", s.oenc_valid, 1);
    core_ready_key = 1'b1;
    repeat (2) step();
    core_ready_key = 1'b0;
    chk("rekey_key_valid", key_valid, 1);
    base_e = n_enc_out;
    s.oenc_ready = 1'b1;
    for (int k = 0; k < 60 && n_enc_out - base_e < 4; k++) step();
    chk("rekey_out_count", n_enc_out - base_e, 4);
    chk("no_spurious_yet", err_spurious, 0);
    man_od = 1'b1;
    step();
    man_od = 1'b0;
    chk("spurious_flag", err_spurious, 1);
    chk("spurious_no_odec", s.odec_valid, 0);
    s.oenc_ready = 1'b0;
    push_blk(1'b0, {4{32'h40000000}});
    push_blk(1'b0, {4{32'h40000001}});
    repeat (14) step();
    chk("pre_reset_oenc_valid", s.oenc_valid, 1);
    push_blk(1'b0, {4{32'h40000002}});
    push_blk(1'b0, {4{32'h40000003}});
    repeat (2) step();
    s.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tx_q.delete();
    exp_enc.delete();
    exp_dec.delete();
    chk("midrst_key_valid", key_valid, 0);
    chk("midrst_in_ready", s.in_ready, 0);
    chk("midrst_oenc_valid", s.oenc_valid, 0);
    chk("midrst_core_key", core_key, 0);
    chk("midrst_err_spurious", err_spurious, 0);
    s.oenc_ready = 1'b1;
    repeat (15) step();
    chk("late_result_spurious", err_spurious, 1);
    chk("late_result_dropped", s.oenc_valid, 0);
    key_load = 1'b1;
    key_in = K1;
    step();
    key_load = 1'b0;
    step();
    repeat (7) step();
    chk("tmo_not_yet", err_timeout, 0);
    step();
    chk("tmo_flag", err_timeout, 1);
    chk("tmo_key_valid", key_valid, 0);
    chk("tmo_in_ready", s.in_ready, 0);
    chk("tmo_spurious_sticky", err_spurious, 1);
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    chk("tmo_back_to_idle", core_reset_key, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
